// File: rtl/font_fetch_arbiter.sv
// Shares the glyph font ROM between display scanout (single-row, high priority) and CPU glyph bursts.
// Defining FONT_STARVE_GUARD_EN adds a starvation guard that forces a CPU slot after STARVE_LIMIT lost slots.
module font_fetch_arbiter
`ifdef FONT_STARVE_GUARD_EN
   #(parameter int STARVE_LIMIT = 8)
`endif
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        disp_req,
   input  logic [7:0]  disp_glyph,
   input  logic [3:0]  disp_row,
   output logic        disp_gnt,
   output logic        disp_rvalid,
   output logic [15:0] disp_rdata,
   input  logic        cpu_req_valid,
   output logic        cpu_req_ready,
   input  logic [7:0]  cpu_glyph,
   output logic        cpu_rsp_valid,
   input  logic        cpu_rsp_ready,
   output logic [3:0]  cpu_rsp_row,
   output logic [15:0] cpu_rsp_data,
   output logic        cpu_rsp_last,
   output logic        cpu_busy,
   output logic [11:0] rom_addr,
   input  logic [15:0] rom_data
);

   typedef enum logic [1:0] {S_IDLE, S_BURST, S_FLUSH} state_t;

   state_t      r_state, w_state_nxt;
   logic [7:0]  r_glyph;
   logic [3:0]  r_row_cnt;
   logic        r_disp_rvalid;
   logic [15:0] r_disp_rdata;
   logic        r_rsp_valid;
   logic [3:0]  r_rsp_row;
   logic [15:0] r_rsp_data;
   logic        r_rsp_last;
   logic        w_cpu_elig;
   logic        w_force_cpu;
   logic        w_cpu_slot;
   logic        w_accept;

   // The response register is single-entry, so the CPU may only fetch when it can take the new beat.
   assign w_cpu_elig = (r_state == S_BURST) && (!r_rsp_valid || cpu_rsp_ready);
   assign disp_gnt   = disp_req && !w_force_cpu;
   assign w_cpu_slot = w_cpu_elig && !disp_gnt;
   assign w_accept   = (r_state == S_IDLE) && cpu_req_valid;

`ifdef FONT_STARVE_GUARD_EN
   localparam int CW = $clog2(STARVE_LIMIT + 1);
   logic [CW-1:0] r_starve;

   assign w_force_cpu = w_cpu_elig && (r_starve == CW'(STARVE_LIMIT));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_starve <= '0;
      else if (w_cpu_slot)
         r_starve <= '0;
      else if (w_cpu_elig && disp_gnt)
         r_starve <= r_starve + CW'(1);
   end
`else
   assign w_force_cpu = 1'b0;
`endif

   always_comb begin
      rom_addr = 12'h000;
      if (disp_gnt)
         rom_addr = {disp_glyph, disp_row};
      else if (w_cpu_slot)
         rom_addr = {r_glyph, r_row_cnt};
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_state_nxt = S_BURST;
         S_BURST: if (w_cpu_slot && (r_row_cnt == 4'hF)) w_state_nxt = S_FLUSH;
         S_FLUSH: if (r_rsp_valid && cpu_rsp_ready && r_rsp_last) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_glyph   <= 8'h00;
         r_row_cnt <= 4'h0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_glyph   <= cpu_glyph;
            r_row_cnt <= 4'h0;
         end else if (w_cpu_slot) begin
            r_row_cnt <= r_row_cnt + 4'h1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_disp_rvalid <= 1'b0;
         r_disp_rdata  <= 16'h0000;
      end else begin
         r_disp_rvalid <= disp_gnt;
         if (disp_gnt)
            r_disp_rdata <= rom_data;
      end
   end

   // A new beat can only be loaded when the previous one is absent or leaving this cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rsp_valid <= 1'b0;
         r_rsp_row   <= 4'h0;
         r_rsp_data  <= 16'h0000;
         r_rsp_last  <= 1'b0;
      end else if (w_cpu_slot) begin
         r_rsp_valid <= 1'b1;
         r_rsp_row   <= r_row_cnt;
         r_rsp_data  <= rom_data;
         r_rsp_last  <= (r_row_cnt == 4'hF);
      end else if (r_rsp_valid && cpu_rsp_ready) begin
         r_rsp_valid <= 1'b0;
      end
   end

   assign disp_rvalid   = r_disp_rvalid;
   assign disp_rdata    = r_disp_rdata;
   assign cpu_rsp_valid = r_rsp_valid;
   assign cpu_rsp_row   = r_rsp_row;
   assign cpu_rsp_data  = r_rsp_data;
   assign cpu_rsp_last  = r_rsp_last;
   assign cpu_req_ready = (r_state == S_IDLE);
   assign cpu_busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_font_fetch_arbiter.sv
// Testbench for font_fetch_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_font_fetch_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        disp_req;
   logic [7:0]  disp_glyph;
   logic [3:0]  disp_row;
   logic        disp_gnt;
   logic        disp_rvalid;
   logic [15:0] disp_rdata;
   logic        cpu_req_valid;
   logic        cpu_req_ready;
   logic [7:0]  cpu_glyph;
   logic        cpu_rsp_valid;
   logic        cpu_rsp_ready;
   logic [3:0]  cpu_rsp_row;
   logic [15:0] cpu_rsp_data;
   logic        cpu_rsp_last;
   logic        cpu_busy;
   logic [11:0] rom_addr;
   logic [15:0] rom_data;

   font_fetch_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .disp_req(disp_req), .disp_glyph(disp_glyph), .disp_row(disp_row),
      .disp_gnt(disp_gnt), .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
      .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready), .cpu_glyph(cpu_glyph),
      .cpu_rsp_valid(cpu_rsp_valid), .cpu_rsp_ready(cpu_rsp_ready), .cpu_rsp_row(cpu_rsp_row),
      .cpu_rsp_data(cpu_rsp_data), .cpu_rsp_last(cpu_rsp_last), .cpu_busy(cpu_busy),
      .rom_addr(rom_addr), .rom_data(rom_data)
   );

   always #5 clk = ~clk;

   // Odd multiplier keeps every 12-bit address mapped to a distinct word.
   function automatic logic [15:0] rom_f(input logic [11:0] a);
      return 16'((32'(a) * 32'd40503) + 32'h1234);
   endfunction

   assign rom_data = rom_f(rom_addr);

   int n_chk   = 0;
   int n_fail  = 0;
   int n_beats = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: one burst in flight, a count of rows fetched, and the pending beat.
   bit          m_active;
   int          m_fetched;
   logic [7:0]  m_glyph;
   bit          m_bv;
   logic [3:0]  m_brow;
   logic [15:0] m_bdata;
   bit          m_blast;
   bit          m_dv;
   logic [15:0] m_dd;
   int          m_lost;
   bit          e_was_active, e_elig, e_forced, e_gnt, e_cslot;
   logic [11:0] e_addr;

   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_disp_rvalid", 32'(disp_rvalid), 0);
         chk("rst_disp_rdata", 32'(disp_rdata), 0);
         chk("rst_rsp_valid", 32'(cpu_rsp_valid), 0);
         chk("rst_rsp_row", 32'(cpu_rsp_row), 0);
         chk("rst_rsp_data", 32'(cpu_rsp_data), 0);
         chk("rst_rsp_last", 32'(cpu_rsp_last), 0);
         chk("rst_busy", 32'(cpu_busy), 0);
         chk("rst_req_ready", 32'(cpu_req_ready), 1);
         m_active = 0; m_fetched = 0; m_glyph = 0; m_bv = 0; m_brow = 0;
         m_bdata = 0; m_blast = 0; m_dv = 0; m_dd = 0; m_lost = 0;
      end else begin
         e_was_active = m_active;
         e_elig   = m_active && (m_fetched < 16) && (!m_bv || cpu_rsp_ready);
         e_forced = 0;
`ifdef FONT_STARVE_GUARD_EN
         e_forced = e_elig && (m_lost == 8);
`endif
         e_gnt   = disp_req && !e_forced;
         e_cslot = e_elig && !e_gnt;
         e_addr  = e_gnt ? {disp_glyph, disp_row} : (e_cslot ? {m_glyph, 4'(m_fetched)} : 12'h000);

         chk("disp_gnt", 32'(disp_gnt), 32'(e_gnt));
         chk("rom_addr", 32'(rom_addr), 32'(e_addr));
         chk("req_ready", 32'(cpu_req_ready), 32'(!e_was_active));
         chk("busy", 32'(cpu_busy), 32'(e_was_active));
         chk("disp_rvalid", 32'(disp_rvalid), 32'(m_dv));
         if (m_dv) chk("disp_rdata", 32'(disp_rdata), 32'(m_dd));
         chk("rsp_valid", 32'(cpu_rsp_valid), 32'(m_bv));
         if (m_bv) begin
            chk("rsp_row", 32'(cpu_rsp_row), 32'(m_brow));
            chk("rsp_data", 32'(cpu_rsp_data), 32'(m_bdata));
            chk("rsp_last", 32'(cpu_rsp_last), 32'(m_blast));
         end

         if (m_bv && cpu_rsp_ready) n_beats++;
         m_dv = e_gnt;
         if (e_gnt) m_dd = rom_f(e_addr);
         if (m_bv && cpu_rsp_ready && m_blast) m_active = 0;
         if (e_cslot) begin
            m_bv = 1; m_brow = 4'(m_fetched); m_bdata = rom_f(e_addr);
            m_blast = (m_fetched == 15); m_fetched++; m_lost = 0;
         end else begin
            if (m_bv && cpu_rsp_ready) m_bv = 0;
            if (e_elig && e_gnt) m_lost++;
         end
         if (!e_was_active && cpu_req_valid) begin
            m_active = 1; m_glyph = cpu_glyph; m_fetched = 0;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input string nm);
      int k = 0;
      while (cpu_busy && k < 300) begin
         @(negedge clk);
         k++;
      end
      chk(nm, 32'(cpu_busy), 0);
   endtask

   task automatic wait_row(input string nm, input logic [3:0] r);
      int k = 0;
      while (!(cpu_rsp_valid && cpu_rsp_row == r) && k < 100) begin
         @(negedge clk);
         k++;
      end
      chk(nm, 32'(cpu_rsp_valid && cpu_rsp_row == r), 1);
   endtask

   int  b0;
   bit  held;

   initial begin
      rst_n = 0; disp_req = 0; disp_glyph = 0; disp_row = 0;
      cpu_req_valid = 0; cpu_glyph = 0; cpu_rsp_ready = 1;
      repeat (2) @(negedge clk);
      step();
      rst_n = 1;

      // single burst, no display traffic
      step();
      cpu_req_valid = 1; cpu_glyph = 8'h41;
      @(negedge clk);
      chk("t1_accept_ready", 32'(cpu_req_ready), 1);
      for (int i = 1; i <= 18; i++) begin
         step();
         cpu_req_valid = 0;
         @(negedge clk);
         if (i == 1)  chk("t1_addr_row0", 32'(rom_addr), 32'h410);
         if (i == 16) chk("t1_addr_row15", 32'(rom_addr), 32'h41F);
         if (i == 17) begin
            chk("t1_last", 32'(cpu_rsp_last), 1);
            chk("t1_last_row", 32'(cpu_rsp_row), 32'hF);
         end
         if (i == 18) chk("t1_busy_low", 32'(cpu_busy), 0);
      end

      // display fetch while idle
      step();
      disp_req = 1; disp_glyph = 8'h12; disp_row = 4'h5;
      @(negedge clk);
      chk("t2_addr", 32'(rom_addr), 32'h125);
      chk("t2_gnt", 32'(disp_gnt), 1);
      step();
      disp_req = 0;
      @(negedge clk);
      chk("t2_rvalid", 32'(disp_rvalid), 1);
      chk("t2_rdata", 32'(disp_rdata), 32'(rom_f(12'h125)));

      // display held high through a CPU burst
      step();
      cpu_req_valid = 1; cpu_glyph = 8'h7E;
      disp_req = 1; disp_glyph = 8'h20; disp_row = 4'h3;
      step();
      cpu_req_valid = 0;
      b0 = n_beats;
      repeat (40) step();
`ifdef FONT_STARVE_GUARD_EN
      chk("t3_guard_beats", 32'((n_beats - b0) >= 3 && (n_beats - b0) <= 5), 1);
`else
      chk("t3_starved_beats", 32'(n_beats - b0), 0);
`endif
      disp_req = 0;
      @(negedge clk);
      wait_idle("t3_done");

      // response backpressure on row 7
      step();
      cpu_req_valid = 1; cpu_glyph = 8'hC3;
      step();
      cpu_req_valid = 0;
      @(negedge clk);
      wait_row("t4_row6", 4'h6);
      for (int i = 0; i < 3; i++) begin
         step();
         cpu_rsp_ready = 0;
         @(negedge clk);
         chk("t4_hold_row", 32'(cpu_rsp_row), 32'h7);
         chk("t4_hold_valid", 32'(cpu_rsp_valid), 1);
      end
      step();
      cpu_rsp_ready = 1;
      @(negedge clk);
      wait_idle("t4_done");

      // reset in the middle of a burst
      step();
      cpu_req_valid = 1; cpu_glyph = 8'h99;
      step();
      cpu_req_valid = 0;
      @(negedge clk);
      wait_row("t5_row8", 4'h8);
      step();
      rst_n = 0;
      @(negedge clk);
      chk("t5_rsp_valid", 32'(cpu_rsp_valid), 0);
      chk("t5_ready", 32'(cpu_req_ready), 1);
      step();
      step();
      rst_n = 1;
      b0 = n_beats;
      repeat (20) step();
      chk("t5_no_stray", 32'(n_beats - b0), 0);

      // simultaneous display and CPU requests while idle
      disp_req = 1; disp_glyph = 8'h33; disp_row = 4'h9;
      cpu_req_valid = 1; cpu_glyph = 8'h5C;
      @(negedge clk);
      chk("t6_gnt", 32'(disp_gnt), 1);
      chk("t6_ready", 32'(cpu_req_ready), 1);
      step();
      disp_req = 0; cpu_req_valid = 0;
      @(negedge clk);
      chk("t6_row0", 32'(rom_addr), 32'h5C0);
      wait_idle("t6_done");

      // randomized traffic
      held = 0;
      for (int c = 0; c < 3000; c++) begin
         step();
         if (!held) begin
            disp_req   = ($urandom_range(0, 99) < 35);
            disp_glyph = 8'($urandom);
            disp_row   = 4'($urandom);
         end
         cpu_req_valid = ($urandom_range(0, 3) == 0);
         cpu_glyph     = 8'($urandom);
         cpu_rsp_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         held = disp_req && !disp_gnt;
      end
      step();
      disp_req = 0; cpu_req_valid = 0; cpu_rsp_ready = 1;
      @(negedge clk);
      wait_idle("rand_drain");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
